// File: rtl/lcd_timed_controller.sv
`timescale 1ns/1ps
// Avalon-MM slave that turns each CPU access into one timed HD44780 bus cycle (setup, E pulse, hold, exec).
// Build option: define LCD_BUSY_POLL_EN to replace the fixed T_EXEC wait with busy-flag polling.
module lcd_timed_controller #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_PULSE  = 12,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_EXEC   = 2000,
    parameter int unsigned POLL_MAX = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  logic [7:0] LCD_data
);

    localparam int unsigned MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int unsigned MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAXP  = (MAX_C > POLL_MAX) ? MAX_C : POLL_MAX;
    localparam int unsigned CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

`ifdef LCD_BUSY_POLL_EN
    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE, S_P_SETUP, S_P_PULSE, S_P_HOLD
    } state_t;

    logic [PW-1:0] r_polls;
    logic          r_busy;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_DONE
    } state_t;
`endif

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rs;
    logic          r_rw;
    logic          r_e;
    logic          r_drive;
    logic [7:0]    r_wdata;
    logic [7:0]    r_readdata;
    logic          w_req;
    logic          w_cnt_zero;
    logic          w_unused_addr0;

    // address[0] has no meaning: the read/write strobe already selects RW.
    assign w_unused_addr0 = address[0];

    assign w_req      = read | write;
    assign w_cnt_zero = (r_cnt == '0);

    assign waitrequest = w_req & (r_state != S_DONE);
    assign readdata    = r_readdata;
    assign LCD_E       = r_e;
    assign LCD_RS      = r_rs;
    assign LCD_RW      = r_rw;
    assign LCD_data    = r_drive ? r_wdata : 'z;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b1;
            r_e        <= 1'b0;
            r_drive    <= 1'b0;
            r_wdata    <= '0;
            r_readdata <= '0;
`ifdef LCD_BUSY_POLL_EN
            r_polls    <= '0;
            r_busy     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rs    <= address[1];
                        r_rw    <= ~write;
                        r_wdata <= writedata;
                        r_drive <= write;
                        if (write) begin
                            r_readdata <= '0;
                        end
`ifdef LCD_BUSY_POLL_EN
                        r_polls <= '0;
                        r_busy  <= 1'b0;
`endif
                        r_cnt   <= CW'(T_SETUP - 1);
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b1;
                        r_cnt   <= CW'(T_PULSE - 1);
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_PULSE: begin
                    if (w_cnt_zero) begin
                        r_e <= 1'b0;
                        if (r_rw) begin
                            r_readdata <= LCD_data;
                        end
                        r_cnt   <= CW'(T_HOLD - 1);
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_HOLD: begin
                    if (w_cnt_zero) begin
                        r_drive <= 1'b0;
                        if (r_rw) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
`ifdef LCD_BUSY_POLL_EN
                            // Busy-flag read: instruction register, read direction.
                            r_rs    <= 1'b0;
                            r_rw    <= 1'b1;
                            r_cnt   <= CW'(T_SETUP - 1);
                            r_state <= S_P_SETUP;
`else
                            r_cnt   <= CW'(T_EXEC - 1);
                            r_state <= S_EXEC;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

`ifdef LCD_BUSY_POLL_EN
                S_P_SETUP: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b1;
                        r_cnt   <= CW'(T_PULSE - 1);
                        r_state <= S_P_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_P_PULSE: begin
                    if (w_cnt_zero) begin
                        r_e     <= 1'b0;
                        r_busy  <= LCD_data[7];
                        r_polls <= r_polls + 1'b1;
                        r_cnt   <= CW'(T_HOLD - 1);
                        r_state <= S_P_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_P_HOLD: begin
                    if (w_cnt_zero) begin
                        if (r_busy && (r_polls < PW'(POLL_MAX))) begin
                            r_cnt   <= CW'(T_SETUP - 1);
                            r_state <= S_P_SETUP;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`else
                S_EXEC: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    // Park the control lines in their reset (read) levels between cycles.
                    r_rs    <= 1'b0;
                    r_rw    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_e     <= 1'b0;
                    r_drive <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
